// File: rtl/imem.sv
// Instruction memory: combinational fetch by word index, clocked write port,
// default program restored on reset. Define IMEM_OOR_FLAG_EN to add oor_err.
module imem #(
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  output logic [WORD_SIZE-1:0]  Instruction,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]  wr_data
`ifdef IMEM_OOR_FLAG_EN
  ,
  output logic                  oor_err
`endif
);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic                 in_range;

  function automatic logic [WORD_SIZE-1:0] default_word(input int idx);
    case (idx)
      0:       default_word = WORD_SIZE'(32'h20010005);
      1:       default_word = WORD_SIZE'(32'h20020003);
      2:       default_word = WORD_SIZE'(32'h00221820);
      3:       default_word = WORD_SIZE'(32'h00222022);
      4:       default_word = WORD_SIZE'(32'hAC030000);
      5:       default_word = WORD_SIZE'(32'h8C050000);
      6:       default_word = WORD_SIZE'(32'h10A3FFF9);
      7:       default_word = WORD_SIZE'(32'h08000000);
      default: default_word = '0;
    endcase
  endfunction

  // Any set bit above the array range makes the fetch a NOP.
  assign in_range    = (PC < 32'(DEPTH));
  assign Instruction = in_range ? mem[PC[ADDR_WIDTH-1:0]] : '0;

`ifdef IMEM_OOR_FLAG_EN
  assign oor_err = ~in_range;
`endif

  // Reset reloads the whole program and overrides any concurrent write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= default_word(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_imem.sv
// Bench for imem: literal spot checks plus randomized writes/fetches/resets
// compared every cycle against an array model of the memory.
module tb_imem;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] Instruction;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
`ifdef IMEM_OOR_FLAG_EN
  logic        oor_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [31:0] model [DEPTH];
  logic [31:0] prog [8] = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h00222022,
                            32'hAC030000, 32'h8C050000, 32'h10A3FFF9, 32'h08000000};

  imem dut (
    .clk(clk), .rst(rst), .PC(PC), .Instruction(Instruction),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_OOR_FLAG_EN
    , .oor_err(oor_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the memory contents as a plain array.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = (i < 8) ? prog[i] : 32'h0;
    end else if (wr_en) begin
      model[wr_addr] = wr_data;
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] pc);
    return (pc < DEPTH) ? model[pc] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (PC=%h t=%0t)", name, act, exp, PC, $time);
    end
  endtask

  // Continuous comparison against the model, away from the write edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model", Instruction, exp_read(PC));
`ifdef IMEM_OOR_FLAG_EN
      check("oor_model", {31'b0, oor_err}, {31'b0, PC >= DEPTH});
`endif
    end
  end

  initial begin
    #1 rst = 1'b1;
    #11 rst = 1'b0;

    // Default program fetches, each valid in the same time step.
    PC = 0; #1 check("pc0", Instruction, 32'h20010005); #9;
    PC = 2; #1 check("pc2", Instruction, 32'h00221820); #9;
    PC = 4; #1 check("pc4", Instruction, 32'hAC030000); #9;
    PC = 5; #1 check("pc5", Instruction, 32'h8C050000); #9;
    PC = 6; #1 check("pc6", Instruction, 32'h10A3FFF9); #9;
    PC = 7; #1 check("pc7", Instruction, 32'h08000000);
    PC = 8; #1 check("pc8", Instruction, 32'h00000000);
    PC = 63; #1 check("pc63", Instruction, 32'h00000000);
`ifdef IMEM_OOR_FLAG_EN
    check("oor63", {31'b0, oor_err}, 32'd0);
`endif
    PC = 64; #1 check("pc64", Instruction, 32'h00000000);
`ifdef IMEM_OOR_FLAG_EN
    check("oor64", {31'b0, oor_err}, 32'd1);
`endif
    PC = 32'hFFFFFFFF; #1 check("pcmax", Instruction, 32'h00000000);
`ifdef IMEM_OOR_FLAG_EN
    check("oormax", {31'b0, oor_err}, 32'd1);
`endif
    chk_en = 1'b1;

    // Read-during-write: old word before the edge, new word after.
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hDEADBEEF; PC = 3;
    #1 check("rdw_before", Instruction, 32'h00222022);
    @(posedge clk); #1 check("rdw_after", Instruction, 32'hDEADBEEF);
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rdw_hold", Instruction, 32'hDEADBEEF);

    // Asynchronous reset discards written words without a clock edge.
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'h12345678;
    @(posedge clk); #2;
    wr_en = 1'b0; PC = 10;
    #1 check("wr10", Instruction, 32'h12345678);
    rst = 1'b1;
    #1 check("rst_pc10", Instruction, 32'h00000000);
    PC = 3;
    #1 check("rst_pc3", Instruction, 32'h00222022);

    // Reset wins over a simultaneous write.
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'hFFFFFFFF; PC = 0;
    @(posedge clk); #1 check("rst_blocks_wr", Instruction, 32'h20010005);
    @(posedge clk); #2;
    wr_en = 1'b0; rst = 1'b0;

    // Randomized writes, fetches (in and out of range) and reset pulses.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    PC = $urandom_range(0, DEPTH - 1);
        2:       PC = {26'b0, wr_addr};
        3:       PC = $urandom_range(DEPTH, 300);
        default: PC = $urandom;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem.md
Name: imem

Overview:
- Instruction memory for the 32-bit multicycle CPU.
- Returns the instruction word selected by PC, combinationally.
- Holds a built-in default program that is restored on reset.
- Provides a clocked write port so the bench or a loader can overwrite program words.

Parameters:
- WORD_SIZE, 32, instruction and data width in bits.
- DEPTH, 64, number of instruction words stored.
- ADDR_WIDTH, 6, width of the write address; must equal log2(DEPTH).

Ports:
- clk  input  1  write clock; rising edge.
- rst  input  1  asynchronous, active-high reset; restores the default program.
- PC  input  32  word index of the instruction to fetch.
- Instruction  output  WORD_SIZE  instruction word at PC.
- wr_en  input  1  write enable, sampled on rising clk.
- wr_addr  input  ADDR_WIDTH  word index to write.
- wr_data  input  WORD_SIZE  word to write.

Behaviour:
- Addressing:
  - PC is a word index, not a byte address; consecutive PC values select consecutive words.
  - No alignment requirement; odd PC values are legal.
- Read:
  - Purely combinational, zero latency: Instruction = mem[PC] whenever PC < DEPTH.
  - When PC >= DEPTH (any upper bits set), Instruction = 32'h00000000 (NOP).
  - No X is ever driven.
- Reset:
  - While rst is high, all words are asynchronously loaded with the default program; the read path reflects it immediately.
  - Words 0-7 are:
    - 0: 32'h20010005
    - 1: 32'h20020003
    - 2: 32'h00221820
    - 3: 32'h00222022
    - 4: 32'hAC030000
    - 5: 32'h8C050000
    - 6: 32'h10A3FFF9
    - 7: 32'h08000000
  - Words 8 to DEPTH-1 are 32'h00000000.
  - The array has no power-up contents other than those set by reset; the bench must pulse rst before the first fetch.
- Write:
  - On rising clk with rst low and wr_en high, mem[wr_addr] <= wr_data.
  - Writes are ignored while rst is high; reset wins over a simultaneous write.
- Read-during-write:
  - If PC equals wr_addr, Instruction shows the old word until the clock edge and the new word immediately after it.
- Reset mid-operation: asserting rst after writes discards every written word and restores the defaults.
- Instruction changes only when PC changes, on a completed write to the word at PC, or on reset.

Optional Feature:
- Macro: IMEM_OOR_FLAG_EN.
- Defined: adds output port oor_err (1 bit).
  - Combinational; high exactly when PC >= DEPTH, low otherwise.
  - Low during reset if PC < DEPTH.
- Not defined: the port does not exist. Out-of-range reads still return 32'h00000000.

Test Plan:
- Pulse rst, then PC = 0, 2, 4, 5, 6 at 10 ns steps -> Instruction = 20010005, 00221820, AC030000, 8C050000, 10A3FFF9; each value is valid in the same time step.
- After reset, PC = 7 -> 08000000; PC = 8 -> 00000000; PC = 63 -> 00000000.
- PC = 64, then PC = 32'hFFFFFFFF -> Instruction = 00000000 both times. With IMEM_OOR_FLAG_EN, oor_err = 1 for both and 0 for PC = 63.
- Read-during-write: wr_en = 1, wr_addr = 3, wr_data = DEADBEEF, PC = 3.
  - Before the edge -> 00222022.
  - After the rising clk -> DEADBEEF.
  - With wr_en = 0, further edges leave DEADBEEF in place.
- Write 12345678 to word 10, then assert rst asynchronously between clock edges -> PC = 10 reads 00000000 and PC = 3 reads 00222022 without waiting for a clock edge.
- Hold rst high with wr_en = 1, wr_addr = 0, wr_data = FFFFFFFF across a clk edge -> PC = 0 still reads 20010005.
